approach_a_to_b_gen: RTL
========================

Name: approach_a_to_b_gen

Overview:
Parametrised successor to the team's fixed 12-bit "move A close to B" RTL exercise. It steps A toward B using a coarse step, then reverses with a fine step, in either direction selected by Mode. It also reports the number of steps taken and flags any out-of-range step. It is a standalone start/ack-handshaked datapath with a one-hot control unit, used in lab exercises and as a reusable search engine.

Parameters:
WIDTH, 12, bit width of Ain, Bin, A, B (unsigned).
COARSE_STEP, 100, coarse increment/decrement; must satisfy 0 < FINE_STEP <= COARSE_STEP < 2^WIDTH.
FINE_STEP, 10, fine increment/decrement.
CNT_W, 8, width of the step counter.

Ports:
Clk  input  1  clock; all state changes on posedge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  begin operation; sampled only in INI.
Ack  input  1  acknowledge result; sampled only in DONE.
Mode  input  1  0 = approach from below (result <= B); 1 = approach from above (result >= B). Latched in INI.
Ain  input  WIDTH  initial A, latched in INI.
Bin  input  WIDTH  target B, latched in INI.
A  output  WIDTH  working/result register.
Count  output  CNT_W  number of steps applied; saturates at all-ones.
Flag  output  1  set when the fine (reversal) phase was entered.
Ovf  output  1  set when a required step would leave [0, 2^WIDTH-1].
Qi, Qc, Qf, Qd  output  1 each  one-hot state bits: INI, COARSE, FINE, DONE.

Behaviour:
- Reset (synchronous; priority over everything, in any state, including mid-operation): next edge gives state = INI, and A, B, Count, Flag, Ovf, Mode-latch all = 0.
- INI: every cycle A<=Ain, B<=Bin, M<=Mode, Count<=0, Flag<=0, Ovf<=0. If Start, go to COARSE; Ain/Bin/Mode are captured on that same edge.
- All arithmetic is done in WIDTH+1 bits to detect range violations. Step results are never wrapped.
- COARSE, M=0:
  - A==B: go to DONE.
  - A<B and A+COARSE_STEP > 2^WIDTH-1: Ovf<=1, go to DONE, A held.
  - A<B otherwise: A<=A+COARSE_STEP, Count++.
  - A>B: A<=A-FINE_STEP, Flag<=1, Count++, go to FINE.
- COARSE, M=1: mirror of M=0.
  - A==B: go to DONE.
  - A>B and A < COARSE_STEP: Ovf<=1, go to DONE, A held.
  - A>B otherwise: A<=A-COARSE_STEP, Count++.
  - A<B: if A+FINE_STEP overflows, Ovf<=1 and go to DONE; else A<=A+FINE_STEP, Flag<=1, Count++, go to FINE.
- FINE, M=0: if A<=B, go to DONE; else A<=A-FINE_STEP, Count++.
- FINE, M=1: if A>=B, go to DONE; else if A+FINE_STEP overflows, Ovf<=1 and go to DONE; else A<=A+FINE_STEP, Count++.
- DONE: A, Count, Flag, Ovf held stable. If Ack, go to INI. Start is ignored in DONE; Ack is ignored elsewhere.
- Count increments only on edges where A changes. At all-ones it holds (no wrap).
- Latency: 1 cycle in INI after Start, plus 1 cycle per step, plus 1 terminating-check cycle; Qd rises on the edge after the last check.
- Ain/Bin/Mode changes after leaving INI have no effect.
- Exactly one of Qi/Qc/Qf/Qd is high at all times after the first reset.

Test Plan:
- Mode=0, Ain=120, Bin=555, Start 1 cycle -> A path 220,320,420,520,620,610..550; DONE with A=550, Count=12, Flag=1, Ovf=0; held until Ack, then INI.
- Mode=1, Ain=900, Bin=555 -> 800,700,600,500,510..560; DONE with A=560, Count=10, Flag=1.
- Mode=0, Ain=100, Bin=500 -> exact hit; DONE with A=500, Count=4, Flag=0.
- Mode=0, WIDTH=12, Ain=4000, Bin=4090 -> next cycle DONE with Ovf=1, A=4000, Count=0. Mode=1, Ain=50, Bin=20 -> Ovf=1, A=50.
- Reset asserted for 1 cycle while in FINE (Ain=120, Bin=555, Mode=0) -> next edge Qi=1 and A=Count=Flag=Ovf=0. A new Start then reruns to A=550.
- In DONE, hold Ack=0 for 5 cycles with Start=1 -> outputs stable, no restart. Ack=1 -> INI. Ain=Bin=7 with Start -> DONE after 1 COARSE cycle, Count=0.

Source files
------------

// File: rtl/approach_a_to_b_gen.sv
// approach_a_to_b_gen: steps A toward B coarse, then back fine, with a
// start/ack handshake and a one-hot control unit.
// Ports: Clk, Reset (sync, active-high), Start, Ack, Mode
//        Ain/Bin in; A result, Count steps, Flag fine-phase,
//        Ovf range error, Qi/Qc/Qf/Qd one-hot state.
module approach_a_to_b_gen #(
  parameter int WIDTH       = 12,
  parameter int COARSE_STEP = 100,
  parameter int FINE_STEP   = 10,
  parameter int CNT_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic [WIDTH-1:0] A,
  output logic [CNT_W-1:0] Count,
  output logic             Flag,
  output logic             Ovf,
  output logic             Qi,
  output logic             Qc,
  output logic             Qf,
  output logic             Qd
);

  typedef enum logic [3:0] {
    S_INI    = 4'b0001,
    S_COARSE = 4'b0010,
    S_FINE   = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  localparam logic [WIDTH:0] CS = (WIDTH+1)'(COARSE_STEP);
  localparam logic [WIDTH:0] FS = (WIDTH+1)'(FINE_STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   a_x, up_c, up_f, dn_c, dn_f;
  logic [CNT_W-1:0] cnt_inc;

  // One extra bit: a set top bit means the step left [0, 2^WIDTH-1].
  assign a_x  = {1'b0, a_q};
  assign up_c = a_x + CS;
  assign up_f = a_x + FS;
  assign dn_c = a_x - CS;
  assign dn_f = a_x - FS;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INI;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_INI: begin
        a_d    = Ain;
        b_d    = Bin;
        m_d    = Mode;
        cnt_d  = '0;
        flag_d = 1'b0;
        ovf_d  = 1'b0;
        if (Start) state_d = S_COARSE;
      end
      S_COARSE: begin
        if (a_q == b_q) begin
          state_d = S_DONE;
        end else if (!m_q) begin
          if (a_q < b_q) begin
            if (up_c[WIDTH]) begin
              ovf_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              a_d   = up_c[WIDTH-1:0];
              cnt_d = cnt_inc;
            end
          end else if (dn_f[WIDTH]) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            a_d     = dn_f[WIDTH-1:0];
            flag_d  = 1'b1;
            cnt_d   = cnt_inc;
            state_d = S_FINE;
          end
        end else begin
          if (a_q > b_q) begin
            if (dn_c[WIDTH]) begin
              ovf_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              a_d   = dn_c[WIDTH-1:0];
              cnt_d = cnt_inc;
            end
          end else if (up_f[WIDTH]) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            a_d     = up_f[WIDTH-1:0];
            flag_d  = 1'b1;
            cnt_d   = cnt_inc;
            state_d = S_FINE;
          end
        end
      end
      S_FINE: begin
        if (!m_q) begin
          if (a_q <= b_q) begin
            state_d = S_DONE;
          end else if (dn_f[WIDTH]) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            a_d   = dn_f[WIDTH-1:0];
            cnt_d = cnt_inc;
          end
        end else begin
          if (a_q >= b_q) begin
            state_d = S_DONE;
          end else if (up_f[WIDTH]) begin
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            a_d   = up_f[WIDTH-1:0];
            cnt_d = cnt_inc;
          end
        end
      end
      S_DONE: begin
        if (Ack) state_d = S_INI;
      end
      default: state_d = S_INI;
    endcase
  end

  assign A     = a_q;
  assign Count = cnt_q;
  assign Flag  = flag_q;
  assign Ovf   = ovf_q;
  assign Qi    = (state_q == S_INI);
  assign Qc    = (state_q == S_COARSE);
  assign Qf    = (state_q == S_FINE);
  assign Qd    = (state_q == S_DONE);

endmodule
